jit_sequencer: RTL
==================

Name: jit_sequencer

Overview:
Parametrised successor to the bytecode fetch/iterate state machine. It accepts JVM bytecode bytes over a valid/ready stream and resolves NOP and WIDE prefixes. It collects operand bytes into a parallel parameter register, then walks the ARM template chain, one ROM address per downstream handshake. It sits between the bytecode RAM reader and the ARM template emitter, and adds flush (branch redirect) and sticky error reporting.

Parameters:
OP_W, 8, bytecode byte width
ADR_W, 8, template ROM address width (ADR_W >= OP_W)
MAXP, 4, max operand bytes per non-wide opcode
PCNT_W, 3, width of operand-count input
WIDE_OP, 8'hC4, WIDE prefix opcode
NOP_OP, 8'h00, NOP opcode

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
flush  in  1  synchronous redirect: abandon current instruction
bc_valid  in  1  bytecode byte available
bc_data  in  OP_W  bytecode byte
bc_ready  out  1  byte accepted when bc_valid&&bc_ready
pcount  in  PCNT_W  operand byte count for bc_data (combinational table lookup)
nxt_adr  in  ADR_W  next template address for com_adr (combinational ROM)
com_adr  out  ADR_W  current template ROM address
emit_valid  out  1  com_adr valid for emitter
emit_ready  in  1  emitter accepts com_adr
jvm_opcode  out  OP_W  latched current opcode
is_wide  out  1  WIDE prefix active for current opcode
params  out  16*MAXP  collected operand bytes, byte 0 in bits [7:0]
param_cnt  out  PCNT_W+1  operand bytes collected
state  out  2  current state
done  out  1  one-cycle pulse when template chain ends
err  out  1  sticky error flag

Behaviour:
- Reset (reset=0, async): state=S_FETCH; com_adr, jvm_opcode, params, param_cnt=0; is_wide, done, err, emit_valid=0; bc_ready=0 until first clk after release.
- States: S_FETCH, S_PARAM, S_ITER, S_ERR.
- S_FETCH: bc_ready=1. On accept:
  - byte==NOP_OP: stay; is_wide unchanged.
  - byte==WIDE_OP: is_wide already 1 -> S_ERR; else set is_wide=1 and stay.
  - Otherwise: latch jvm_opcode; clear params and param_cnt; need = pcount<<is_wide.
    - need > 2*MAXP -> S_ERR.
    - need==0 -> S_ITER with com_adr=zero-extended byte.
    - else -> S_PARAM.
- S_PARAM: bc_ready=1. Each accepted byte is written to params byte lane param_cnt, and param_cnt increments. After the byte that makes param_cnt==need: com_adr<=jvm_opcode, go to S_ITER. No bubble cycle between bytes.
- S_ITER: bc_ready=0; emit_valid=1; com_adr is held stable while emit_ready=0.
  - On emit_ready with nxt_adr!=0: com_adr<=nxt_adr.
  - On emit_ready with nxt_adr==0: pulse done, clear is_wide, go to S_FETCH.
- S_ERR: err=1; bc_ready=0; emit_valid=0. Held until reset; flush does not clear it.
- flush=1 (in any state except S_ERR):
  - Next state is S_FETCH; is_wide, param_cnt, emit_valid, done=0.
  - Any byte offered in the same cycle is not consumed: bc_ready=0 while flush=1.
  - Flush has priority over all simultaneous events.
- params and jvm_opcode hold their values until the next opcode is accepted.
- Opcode-to-first-address latency: 1 cycle after the last operand byte (or after the opcode if it has no operands).

Decomposition:
- Package jit_seq_pkg: state encodings, NOP_OP/WIDE_OP defaults, operand-byte lane width.
- One sub-module is natural: jit_param_collector (params byte register, param_cnt, clear/write-enable).

Test Plan:
- Bytes 00,00,10(pcount=1),05 -> NOPs skipped; params[7:0]=05; com_adr=10 one cycle later; template chain ends with nxt_adr=0 -> done pulse; returns to S_FETCH.
- Bytes C4,15(pcount=1),01,02 -> is_wide=1, need=2, params[15:0]=0201; is_wide=0 after done.
- Opcode 60 (pcount=0), nxt_adr chain 60->61->00, emit_ready low 3 cycles -> com_adr holds 60 throughout; then 61; then done.
- C4,C4 -> err=1 and bc_ready=0; err persists through flush; cleared only by reset.
- flush during S_PARAM after 1 of 2 operand bytes -> S_FETCH next cycle; param_cnt=0; flush-cycle byte not consumed.
- Reset asserted mid-S_ITER -> all outputs at reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/jit_seq_pkg.sv
// Shared types and defaults for the bytecode sequencer: state encoding,
// default prefix opcodes and operand byte-lane width.
package jit_seq_pkg;
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_PARAM = 2'd1,
        S_ITER  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam int         LANE_W      = 8;
    localparam logic [7:0] DEF_NOP_OP  = 8'h00;
    localparam logic [7:0] DEF_WIDE_OP = 8'hC4;
endpackage

// File: rtl/jit_param_collector.sv
// Operand byte register: one byte lane per possible operand, written at
// lane param_cnt, with a full clear on a new opcode and a count-only clear.
module jit_param_collector
    import jit_seq_pkg::*;
#(
    parameter int MAXP   = 4,
    parameter int PCNT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  cnt_clr,
    input  logic                  wr_en,
    input  logic [LANE_W-1:0]     wr_data,
    output logic [16*MAXP-1:0]    params,
    output logic [PCNT_W:0]       param_cnt
);
    localparam int              NLANE = 2 * MAXP;
    localparam logic [PCNT_W:0] ONE   = (PCNT_W + 1)'(1);

    logic [LANE_W-1:0] lanes [NLANE];

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                lanes[i] <= '0;
            else if (clr)
                lanes[i] <= '0;
            else if (wr_en && param_cnt == (PCNT_W + 1)'(i))
                lanes[i] <= wr_data;
        end
        assign params[i*LANE_W +: LANE_W] = lanes[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            param_cnt <= '0;
        else if (clr || cnt_clr)
            param_cnt <= '0;
        else if (wr_en)
            param_cnt <= param_cnt + ONE;
    end
endmodule

// File: rtl/jit_sequencer.sv
// Bytecode fetch/iterate sequencer: strips NOP/WIDE prefixes, gathers operand
// bytes, then walks the template ROM chain one address per emitter handshake.
module jit_sequencer
    import jit_seq_pkg::*;
#(
    parameter int               OP_W    = 8,
    parameter int               ADR_W   = 8,
    parameter int               MAXP    = 4,
    parameter int               PCNT_W  = 3,
    parameter logic [OP_W-1:0]  WIDE_OP = OP_W'(DEF_WIDE_OP),
    parameter logic [OP_W-1:0]  NOP_OP  = OP_W'(DEF_NOP_OP)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                bc_valid,
    input  logic [OP_W-1:0]     bc_data,
    output logic                bc_ready,
    input  logic [PCNT_W-1:0]   pcount,
    input  logic [ADR_W-1:0]    nxt_adr,
    output logic [ADR_W-1:0]    com_adr,
    output logic                emit_valid,
    input  logic                emit_ready,
    output logic [OP_W-1:0]     jvm_opcode,
    output logic                is_wide,
    output logic [16*MAXP-1:0]  params,
    output logic [PCNT_W:0]     param_cnt,
    output logic [1:0]          state,
    output logic                done,
    output logic                err
);
    localparam logic [PCNT_W:0] MAX_NEED = (PCNT_W + 1)'(2 * MAXP);
    localparam logic [PCNT_W:0] ONE      = (PCNT_W + 1)'(1);

    state_t            st, st_nxt;
    logic              rdy_en;
    logic [PCNT_W:0]   need_q, need_new, pc_ext, cnt_inc;
    logic              accept, is_op, param_last, emit_hs, kill;

    assign pc_ext     = {1'b0, pcount};
    assign need_new   = is_wide ? (pc_ext << 1) : pc_ext;
    assign accept     = bc_valid && bc_ready;
    assign is_op      = accept && (st == S_FETCH) && (bc_data != NOP_OP) && (bc_data != WIDE_OP);
    assign cnt_inc    = param_cnt + ONE;
    assign param_last = cnt_inc == need_q;
    assign emit_hs    = emit_valid && emit_ready;
    assign kill       = flush && (st != S_ERR);
    assign state      = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= S_FETCH;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            S_FETCH: if (accept) begin
                if (bc_data == WIDE_OP && is_wide) st_nxt = S_ERR;
                else if (is_op) begin
                    if (need_new > MAX_NEED)  st_nxt = S_ERR;
                    else if (need_new == '0) st_nxt = S_ITER;
                    else                      st_nxt = S_PARAM;
                end
            end
            S_PARAM: if (accept && param_last) st_nxt = S_ITER;
            S_ITER:  if (emit_hs && nxt_adr == '0) st_nxt = S_FETCH;
            default: st_nxt = st;
        endcase
        if (kill) st_nxt = S_FETCH;
    end

    // rdy_en keeps bc_ready low until the first clock after reset release.
    always_comb begin
        bc_ready   = 1'b0;
        emit_valid = 1'b0;
        err        = 1'b0;
        case (st)
            S_FETCH, S_PARAM: bc_ready = rdy_en && !flush;
            S_ITER:           emit_valid = !flush;
            default:          err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en     <= 1'b0;
            com_adr    <= '0;
            jvm_opcode <= '0;
            is_wide    <= 1'b0;
            done       <= 1'b0;
            need_q     <= '0;
        end else begin
            rdy_en <= 1'b1;
            done   <= 1'b0;
            if (kill) begin
                is_wide <= 1'b0;
            end else begin
                if (accept && st == S_FETCH && bc_data == WIDE_OP && !is_wide)
                    is_wide <= 1'b1;
                if (is_op) begin
                    jvm_opcode <= bc_data;
                    need_q     <= need_new;
                    if (need_new == '0) com_adr <= ADR_W'(bc_data);
                end
                if (accept && st == S_PARAM && param_last)
                    com_adr <= ADR_W'(jvm_opcode);
                if (st == S_ITER && emit_hs) begin
                    if (nxt_adr != '0) com_adr <= nxt_adr;
                    else begin
                        done    <= 1'b1;
                        is_wide <= 1'b0;
                    end
                end
            end
        end
    end

    jit_param_collector #(.MAXP(MAXP), .PCNT_W(PCNT_W)) u_params (
        .clk       (clk),
        .reset     (reset),
        .clr       (is_op),
        .cnt_clr   (kill),
        .wr_en     (accept && st == S_PARAM),
        .wr_data   (LANE_W'(bc_data)),
        .params    (params),
        .param_cnt (param_cnt)
    );
endmodule
